// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU/load and MUL/DIV results onto the single register-file write port.
// It also tracks pending MUL/DIV destinations. Define WB_BYPASS_EN to let idle MUL/DIV results skip the FIFO.
module regfile_writeback_arbiter #(
   parameter int MD_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        md_valid,
   output logic        md_ready,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic [31:0] pending_mask,
   output logic        alu_hold,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wdata
);

   localparam int AW   = $clog2(MD_FIFO_DEPTH);
   localparam int CNTW = $clog2(MD_FIFO_DEPTH + 1);
   localparam int SW   = $clog2(STARVE_LIMIT + 1);

   logic [4:0]      fifo_rd_q   [MD_FIFO_DEPTH];
   logic [31:0]     fifo_data_q [MD_FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            md_ready_q, md_ready_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_rd_q, rf_rd_d;
   logic [31:0]     rf_wdata_q, rf_wdata_d;
   logic [31:0]     pending_q, pending_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            alu_hold_q, alu_hold_d;

   logic            fifo_empty, fifo_full;
   logic            push, pop, bypass, md_load, load;
   logic [4:0]      load_rd;
   logic [31:0]     load_data;
   logic [31:0]     pend_set, pend_clr;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNTW'(MD_FIFO_DEPTH));

`ifdef WB_BYPASS_EN
   assign bypass = !alu_valid && fifo_empty && md_valid && md_ready_q;
`else
   assign bypass = 1'b0;
`endif

   assign pop     = !alu_valid && !fifo_empty;
   assign push    = md_valid && md_ready_q && !bypass;
   assign md_load = pop || bypass;

   always_comb begin
      load      = 1'b0;
      load_rd   = '0;
      load_data = '0;
      if (alu_valid) begin
         load      = 1'b1;
         load_rd   = alu_rd;
         load_data = alu_data;
      end else if (pop) begin
         load      = 1'b1;
         load_rd   = fifo_rd_q[rd_ptr_q];
         load_data = fifo_data_q[rd_ptr_q];
      end else if (bypass) begin
         load      = 1'b1;
         load_rd   = md_rd;
         load_data = md_data;
      end

      // x0 destinations are consumed but never reach the register file
      rf_we_d    = load && (load_rd != 5'd0);
      rf_rd_d    = rf_we_d ? load_rd   : rf_rd_q;
      rf_wdata_d = rf_we_d ? load_data : rf_wdata_q;

      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q + CNTW'(push) - CNTW'(pop);
      md_ready_d = (count_d != CNTW'(MD_FIFO_DEPTH));

      pend_clr = '0;
      pend_set = '0;
      if (md_load && (load_rd != 5'd0)) pend_clr[load_rd] = 1'b1;
      if (issue_valid && (issue_rd != 5'd0)) pend_set[issue_rd] = 1'b1;
      pending_d = (pending_q & ~pend_clr) | pend_set;

      starve_d   = '0;
      alu_hold_d = 1'b0;
      if (fifo_full && alu_valid) begin
         if ((starve_q + SW'(1)) == SW'(STARVE_LIMIT)) alu_hold_d = 1'b1;
         else                                          starve_d   = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= md_rd;
         fifo_data_q[wr_ptr_q] <= md_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         md_ready_q <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         pending_q  <= '0;
         starve_q   <= '0;
         alu_hold_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         md_ready_q <= md_ready_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         pending_q  <= pending_d;
         starve_q   <= starve_d;
         alu_hold_q <= alu_hold_d;
      end
   end

   assign md_ready     = md_ready_q;
   assign rf_we        = rf_we_q;
   assign rf_rd        = rf_rd_q;
   assign rf_wdata     = rf_wdata_q;
   assign pending_mask = pending_q;
   assign alu_hold     = alu_hold_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_regfile_writeback_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, md_valid, issue_valid;
   logic [4:0]  alu_rd, md_rd, issue_rd;
   logic [31:0] alu_data, md_data;
   logic        md_ready, alu_hold, rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata, pending_mask;

   int n_checks = 0;
   int n_errors = 0;

   regfile_writeback_arbiter #(.MD_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .pending_mask(pending_mask), .alu_hold(alu_hold),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [4:0]  mq_rd[$];
   logic [31:0] mq_data[$];
   logic        m_we, m_hold, m_ready;
   logic [4:0]  m_rd;
   logic [31:0] m_wdata, m_pend;
   int          m_starve;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq_rd.delete();
      mq_data.delete();
      m_we = 0; m_hold = 0; m_ready = 0;
      m_rd = '0; m_wdata = '0; m_pend = '0;
      m_starve = 0;
   endtask

   task automatic model_step();
      bit          full_prev, accept, used, has, from_md;
      logic [4:0]  wr;
      logic [31:0] wd;
      full_prev = (mq_rd.size() == DEPTH);
      accept    = md_valid && m_ready;
      used = 0; has = 0; from_md = 0; wr = '0; wd = '0;
      if (alu_valid) begin
         has = 1; wr = alu_rd; wd = alu_data;
      end else if (mq_rd.size() > 0) begin
         has = 1; from_md = 1;
         wr = mq_rd.pop_front();
         wd = mq_data.pop_front();
      end
`ifdef WB_BYPASS_EN
      else if (accept) begin
         has = 1; from_md = 1; used = 1; wr = md_rd; wd = md_data;
      end
`endif
      if (accept && !used) begin
         mq_rd.push_back(md_rd);
         mq_data.push_back(md_data);
      end
      m_we = has && (wr != 0);
      if (m_we) begin
         m_rd = wr; m_wdata = wd;
      end
      if (from_md && wr != 0) m_pend[wr] = 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (full_prev && alu_valid) begin
         m_starve++;
         if (m_starve == LIMIT) begin
            m_hold = 1; m_starve = 0;
         end else m_hold = 0;
      end else begin
         m_starve = 0; m_hold = 0;
      end
      m_ready = (mq_rd.size() != DEPTH);
   endtask

   task automatic compare();
      check_eq("rf_we", rf_we, m_we);
      if (m_we) begin
         check_eq("rf_rd", rf_rd, m_rd);
         check_eq("rf_wdata", rf_wdata, m_wdata);
      end
      check_eq("pending_mask", pending_mask, m_pend);
      check_eq("alu_hold", alu_hold, m_hold);
      check_eq("md_ready", md_ready, m_ready);
   endtask

   task automatic idle();
      alu_valid = 0; md_valid = 0; issue_valid = 0;
      alu_rd = '0; md_rd = '0; issue_rd = '0;
      alu_data = '0; md_data = '0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic alu_in(input logic [4:0] rd, input logic [31:0] d);
      alu_valid = 1; alu_rd = rd; alu_data = d;
   endtask

   task automatic md_in(input logic [4:0] rd, input logic [31:0] d);
      md_valid = 1; md_rd = rd; md_data = d;
   endtask

   initial begin
      int pa;
      rst_n = 0;
      idle();
      model_reset();
      #1;
      compare();
      check_eq("reset_rf_rd", rf_rd, 32'd0);
      check_eq("reset_rf_wdata", rf_wdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      compare();
      tick();
      check_eq("ready_after_reset", md_ready, 32'd1);

      // ALU path, latency 1, then idle holds index/data
      alu_in(5'd5, 32'hDEADBEEF); tick();
      check_eq("alu_we", rf_we, 32'd1);
      check_eq("alu_rd", rf_rd, 32'd5);
      check_eq("alu_wdata", rf_wdata, 32'hDEADBEEF);
      check_eq("alu_pending", pending_mask, 32'd0);
      idle(); tick();
      check_eq("idle_we", rf_we, 32'd0);
      check_eq("idle_rd_hold", rf_rd, 32'd5);
      check_eq("idle_wdata_hold", rf_wdata, 32'hDEADBEEF);

      // x0 results are consumed without a write
      alu_in(5'd0, 32'h1234); tick();
      check_eq("x0_alu_we", rf_we, 32'd0);
      alu_in(5'd2, 32'h2); md_in(5'd0, 32'h55); tick();
      idle(); tick();
      check_eq("x0_md_we", rf_we, 32'd0);
      check_eq("x0_md_drained", md_ready, 32'd1);
      tick();

      // collision: ALU wins 3 cycles, md results drain in order afterwards
      alu_in(5'd1, 32'h101); md_in(5'd7, 32'h11); tick();
      alu_in(5'd1, 32'h102); md_in(5'd8, 32'h22); tick();
      check_eq("coll_ready_full", md_ready, 32'd0);
      idle(); alu_in(5'd1, 32'h103); tick();
      check_eq("coll_ready_still0", md_ready, 32'd0);
      idle(); tick();
      check_eq("coll_w1_rd", rf_rd, 32'd7);
      check_eq("coll_w1_data", rf_wdata, 32'h11);
      tick();
      check_eq("coll_w2_rd", rf_rd, 32'd8);
      check_eq("coll_w2_data", rf_wdata, 32'h22);
      tick();

      // scoreboard set / clear
      issue_valid = 1; issue_rd = 5'd9; tick();
      check_eq("sb_set9", pending_mask[9], 32'd1);
      idle(); md_in(5'd9, 32'h99); tick();
`ifdef WB_BYPASS_EN
      check_eq("byp_x9_we", rf_we, 32'd1);
      check_eq("byp_x9_rd", rf_rd, 32'd9);
      check_eq("sb_clr9", pending_mask[9], 32'd0);
      idle(); tick();
`else
      check_eq("sb_still9", pending_mask[9], 32'd1);
      check_eq("md_lat_we", rf_we, 32'd0);
      idle(); tick();
      check_eq("md_x9_we", rf_we, 32'd1);
      check_eq("md_x9_rd", rf_rd, 32'd9);
      check_eq("sb_clr9", pending_mask[9], 32'd0);
`endif
      // same-cycle issue and writeback of x9: set wins
      idle(); issue_valid = 1; issue_rd = 5'd9; tick();
      idle(); alu_in(5'd1, 32'h104); md_in(5'd9, 32'h9A); tick();
      idle(); issue_valid = 1; issue_rd = 5'd9; tick();
      check_eq("sb_same_we", rf_we, 32'd1);
      check_eq("sb_same_data", rf_wdata, 32'h9A);
      check_eq("sb_set_wins", pending_mask[9], 32'd1);
      idle(); tick();

      // starvation: FIFO full while ALU keeps winning
      alu_in(5'd2, 32'h201); md_in(5'd10, 32'hA0); tick();
      alu_in(5'd2, 32'h202); md_in(5'd11, 32'hB0); tick();
      idle();
      for (int k = 0; k < LIMIT; k++) begin
         alu_in(5'd3, 32'h300 + k); tick();
         check_eq("starve_hold", alu_hold, (k == LIMIT - 1) ? 32'd1 : 32'd0);
      end
      idle(); tick();
      check_eq("starve_drain_rd", rf_rd, 32'd10);
      check_eq("starve_hold_drop", alu_hold, 32'd0);
      alu_in(5'd4, 32'h400); md_in(5'd12, 32'hC0); tick();
      idle();
      for (int k = 0; k < LIMIT; k++) begin
         alu_in(5'd4, 32'h410 + k); tick();
         check_eq("restart_hold", alu_hold, (k == LIMIT - 1) ? 32'd1 : 32'd0);
      end
      idle(); tick();
      check_eq("restart_drain_rd", rf_rd, 32'd11);
      tick();
      tick();

      // async reset mid-burst
      issue_valid = 1; issue_rd = 5'd12; tick();
      idle(); issue_valid = 1; issue_rd = 5'd13; alu_in(5'd3, 32'h33); md_in(5'd12, 32'hC1); tick();
      idle(); alu_in(5'd4, 32'h44); md_in(5'd13, 32'hD1); tick();
      check_eq("pre_rst_we", rf_we, 32'd1);
      idle();
      #2 rst_n = 0;
      model_reset();
      #1;
      check_eq("rst_we", rf_we, 32'd0);
      check_eq("rst_pending", pending_mask, 32'd0);
      check_eq("rst_rd", rf_rd, 32'd0);
      check_eq("rst_wdata", rf_wdata, 32'd0);
      compare();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      compare();
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("post_rst_we", rf_we, 32'd0);
      end

`ifdef WB_BYPASS_EN
      md_in(5'd3, 32'h333); tick();
      check_eq("byp_x3_we", rf_we, 32'd1);
      check_eq("byp_x3_rd", rf_rd, 32'd3);
      check_eq("byp_x3_data", rf_wdata, 32'h333);
      idle(); tick();
`endif

      // random traffic, alternating light and heavy ALU load
      for (int i = 0; i < 600; i++) begin
         pa = ((i / 100) % 2 == 1) ? 85 : 35;
         alu_valid   = ($urandom_range(99) < pa) && !m_hold;
         alu_rd      = 5'($urandom_range(31));
         alu_data    = $urandom();
         md_valid    = 1'($urandom_range(1));
         md_rd       = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
         md_data     = $urandom();
         issue_valid = ($urandom_range(99) < 30);
         issue_rd    = 5'($urandom_range(31));
         tick();
      end
      idle();
      for (int k = 0; k < 4; k++) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
